// File: rtl/block_memory_if.sv
// Block-transfer request/response bundle for block_memory.
// The slave modport is the memory side; the master modport is the requester side.
interface block_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BLOCK_SIZE = 16
) ();
  logic [ADDR_WIDTH-1:0]            addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_in;
  logic                             read;
  logic                             write;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_out;
  logic                             ready;
  logic                             busy;

  modport slave (
    input  addr, data_in, read, write,
    output data_out, ready, busy
  );

  modport master (
    output addr, data_in, read, write,
    input  data_out, ready, busy
  );
endinterface

// File: rtl/block_memory.sv
// Block memory with a fixed-latency, one-request-at-a-time block read/write engine.
// Define BLOCK_MEMORY_STATS_EN to add 32-bit read_count/write_count completion counters.
module block_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BLOCK_SIZE = 16,
  parameter int LATENCY    = 4
) (
  input  logic clk,
  input  logic rst,
  block_memory_if.slave bus
`ifdef BLOCK_MEMORY_STATS_EN
  ,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
  logic [BLOCK_BITS-1:0]   rdata_q, rdata_d;
  logic                    is_write_q, is_write_d;
  logic                    fire;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

  // fire marks the single cycle in which the latched access actually executes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    fire       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.read || bus.write) begin
          state_d    = WAIT;
          cnt_d      = CNT_LOAD;
          addr_d     = bus.addr & ALIGN_MASK;
          wdata_d    = bus.data_in;
          is_write_d = bus.write;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          fire    = 1'b1;
          state_d = DONE;
          if (!is_write_q) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
              rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[addr_q + ADDR_WIDTH'(i)];
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // No reset on the array: contents survive rst, and an aborted write never fires.
  always_ff @(posedge clk) begin
    if (fire && is_write_q) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        mem[addr_q + ADDR_WIDTH'(i)] <= wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ready    = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.data_out = rdata_q;

`ifdef BLOCK_MEMORY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (fire) begin
      if (is_write_q) begin
        write_count <= write_count + 32'd1;
      end else begin
        read_count <= read_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory: directed vector table, hand-written corner
// sequences and randomized traffic compared against an array-based reference model.
module tb_block_memory;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int BS  = 4;
  localparam int LAT = 3;
  localparam int BB  = DW * BS;

  logic clk;
  logic rst;

  block_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

`ifdef BLOCK_MEMORY_STATS_EN
  logic [31:0] readCount;
  logic [31:0] writeCount;
`endif

  block_memory #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BLOCK_MEMORY_STATS_EN
    ,
    .read_count(readCount),
    .write_count(writeCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] refMem [1 << AW];
  logic [BB-1:0] refDout;
  int            refReads;
  int            refWrites;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
    logic          checkData;
    logic [BB-1:0] expData;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BB-1:0] refBlock(input logic [AW-1:0] a);
    logic [BB-1:0] blk;
    int base;
    base = (int'(a) / BS) * BS;
    for (int i = 0; i < BS; i++) blk[i*DW +: DW] = refMem[base + i];
    return blk;
  endfunction

  task automatic refApply(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [BB-1:0] d);
    int base;
    base = (int'(a) / BS) * BS;
    if (wr) begin
      for (int i = 0; i < BS; i++) refMem[base + i] = d[i*DW +: DW];
      refWrites++;
    end else if (rd) begin
      refDout = refBlock(a);
      refReads++;
    end
  endtask

  // Issues one request and watches busy/ready from the accepting edge until idle.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [AW-1:0] a,
                               input logic [BB-1:0] d, output int latency,
                               output int busyCycles, output int readyPulses);
    @(negedge clk);
    bus.write   = wr;
    bus.read    = rd;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
    latency = -1;
    busyCycles = 0;
    readyPulses = 0;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      if (bus.busy) busyCycles++;
      if (bus.ready) begin
        readyPulses++;
        if (latency < 0) latency = s;
      end
      if (!bus.busy) break;
    end
  endtask

  task automatic checkStats(input string tag);
`ifdef BLOCK_MEMORY_STATS_EN
    checkOutput({tag, " read_count"}, BB'(readCount), BB'(refReads));
    checkOutput({tag, " write_count"}, BB'(writeCount), BB'(refWrites));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  task automatic runOp(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [BB-1:0] d, input string tag);
    int latency, busyCycles, readyPulses;
    applyStimulus(wr, rd, a, d, latency, busyCycles, readyPulses);
    refApply(wr, rd, a, d);
    checkOutput({tag, " latency"}, BB'(latency), BB'(LAT));
    checkOutput({tag, " busy cycles"}, BB'(busyCycles), BB'(LAT + 1));
    checkOutput({tag, " ready pulses"}, BB'(readyPulses), BB'(1));
    checkOutput({tag, " data_out"}, bus.data_out, refDout);
    checkStats(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency, busyCycles, readyPulses;
    logic [AW-1:0] ra;
    logic [BB-1:0] rdat;
    int op;

    vecs[0] = '{1'b1, 1'b0, 8'h10, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, '0};
    vecs[1] = '{1'b0, 1'b1, 8'h12, '0, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[2] = '{1'b1, 1'b1, 8'h20, {4{32'h5}}, 1'b0, '0};
    vecs[3] = '{1'b0, 1'b1, 8'h20, '0, 1'b1, {4{32'h5}}};
    vecs[4] = '{1'b1, 1'b0, 8'h00, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, '0};
    vecs[5] = '{1'b1, 1'b0, 8'hFC, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 1'b0, '0};
    vecs[6] = '{1'b0, 1'b1, 8'hFC, '0, 1'b1, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}};
    vecs[7] = '{1'b0, 1'b1, 8'h00, '0, 1'b1, {32'h44, 32'h33, 32'h22, 32'h11}};

    rst = 1'b1;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    refDout = '0;
    refReads = 0;
    refWrites = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", BB'(bus.ready), BB'(0));
    checkOutput("reset busy", BB'(bus.busy), BB'(0));
    checkOutput("reset data_out", bus.data_out, '0);
    checkStats("reset");
    rst = 1'b0;

    // Give every word a known value so any later read has a defined expectation.
    for (int b = 0; b < (1 << AW) / BS; b++) begin
      runOp(1'b1, 1'b0, AW'(b * BS), {$urandom, $urandom, $urandom, $urandom}, "fill");
    end

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      if (vecs[i].checkData) begin
        checkOutput($sformatf("vec%0d table data", i), bus.data_out, vecs[i].expData);
      end
    end

    // Write aborted by reset in the second WAIT cycle must leave memory untouched.
    runOp(1'b1, 1'b0, 8'h40, {4{32'h30}}, "w30");
    @(negedge clk);
    bus.write = 1'b1;
    bus.addr = 8'h40;
    bus.data_in = {4{32'h99}};
    @(posedge clk);
    #1 bus.write = 1'b0;
    @(posedge clk);
    #1 checkOutput("abort busy before rst", BB'(bus.busy), BB'(1));
    checkOutput("abort data_out before rst", bus.data_out, {32'h44, 32'h33, 32'h22, 32'h11});
    #1 rst = 1'b1;
    #1 checkOutput("abort ready", BB'(bus.ready), BB'(0));
    checkOutput("abort busy", BB'(bus.busy), BB'(0));
    checkOutput("abort data_out", bus.data_out, '0);
    refDout = '0;
    refReads = 0;
    refWrites = 0;
    checkStats("abort");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runOp(1'b0, 1'b1, 8'h40, '0, "rd40");
    checkOutput("abort memory kept", bus.data_out, {4{32'h30}});

    // Extra read requests during WAIT and DONE must be dropped, not queued.
    @(negedge clk);
    bus.read = 1'b1;
    bus.addr = 8'h00;
    @(posedge clk);
    #1 bus.read = 1'b0;
    latency = -1;
    busyCycles = 0;
    readyPulses = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (bus.busy) busyCycles++;
      if (bus.ready) begin
        readyPulses++;
        if (latency < 0) latency = s;
      end
      bus.read = (s == 1 || s == 3);
    end
    bus.read = 1'b0;
    refApply(1'b0, 1'b1, 8'h00, '0);
    checkOutput("ignore latency", BB'(latency), BB'(LAT));
    checkOutput("ignore busy cycles", BB'(busyCycles), BB'(LAT + 1));
    checkOutput("ignore ready pulses", BB'(readyPulses), BB'(1));
    checkOutput("ignore data_out", bus.data_out, refDout);
    checkStats("ignore");

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      ra = AW'($urandom);
      rdat = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      runOp(op != 0, op != 1, ra, rdat, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/block_memory.md
BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width; depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter BLOCK_SIZE, default 16, words per block transfer; power of two, at most 2^ADDR_WIDTH.
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request acceptance to ready; legal values 1..255.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port addr, input, ADDR_WIDTH bits, word address of the block; low log2(BLOCK_SIZE) bits ignored.
REQ-008 SHALL have port data_in, input, BLOCK_SIZE*DATA_WIDTH bits, write block; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port read, input, 1 bit, read request.
REQ-010 SHALL have port write, input, 1 bit, write request.
REQ-011 SHALL have port data_out, output, BLOCK_SIZE*DATA_WIDTH bits, read block, same packing as data_in.
REQ-012 SHALL have port ready, output, 1 bit, one-cycle completion pulse for either operation.
REQ-013 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 In IDLE, a rising edge with read or write high SHALL accept the request: latch aligned addr, data_in and op; go to WAIT with latency counter loaded to LATENCY-1.
REQ-016 read and write both high in IDLE SHALL be accepted as a write; the read is dropped.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at 0 the access SHALL execute and the FSM SHALL go to DONE, so ready is high exactly LATENCY cycles after the accepting edge.
REQ-018 A write SHALL store all BLOCK_SIZE latched words at aligned_addr+i, using the data_in value latched at acceptance.
REQ-019 A read SHALL load data_out word i from aligned_addr+i on the edge that enters DONE.
REQ-020 data_out SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-021 DONE SHALL last one cycle with ready=1, then return to IDLE; requests in WAIT or DONE SHALL be ignored, not queued.
REQ-022 Minimum spacing between accepted requests SHALL be LATENCY+2 cycles.
REQ-023 A read after a write to the same block SHALL return the written data.

Reset
REQ-024 rst high SHALL immediately force state IDLE, ready=0, busy=0, data_out=0 and counter=0, independent of clk.
REQ-025 Reset during WAIT SHALL abort the operation; a pending write SHALL NOT modify memory.
REQ-026 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro BLOCK_MEMORY_STATS_EN defined, the block SHALL add 32-bit outputs read_count and write_count, reset to 0, each incremented on completion (DONE entry) of its op type, wrapping at 2^32.
REQ-028 Without BLOCK_MEMORY_STATS_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification (bench: DATA_WIDTH=32, ADDR_WIDTH=8, BLOCK_SIZE=4, LATENCY=3)
REQ-029 Write addr=0x10 with data words 0xA0..0xA3, then read addr=0x12 -> ready 3 cycles after each acceptance; read data_out = A3,A2,A1,A0 (word3..word0).
REQ-030 read and write both high at addr=0x20 with data 0x5 in every word, then read 0x20 -> all words 0x5; write_count=1, read_count=1 with BLOCK_MEMORY_STATS_EN.
REQ-031 Write 0x30 to all words at addr=0x40, then write 0x99 to all words at 0x40 and assert rst in cycle 2 of WAIT; read 0x40 -> all words 0x30; ready, busy, data_out low/zero immediately on rst.
REQ-032 Second read pulsed during WAIT of a first read at 0x00 -> only one ready pulse; busy high for 4 cycles.
REQ-033 Write then read top block addr=0xFC -> data_out equals written block; no wrap into address 0x00.
